// File: rtl/d_ram_arb_pkg.sv
// rtl/d_ram_arb_pkg.sv - shared types and width defaults for the data RAM port arbiter
package d_ram_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/d_ram_port_arbiter_if.sv
// rtl/d_ram_port_arbiter_if.sv - requester and RAM-side signal bundle for the data RAM arbiter
interface d_ram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  ram_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output ram_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/d_ram_rd_tag_pipe.sv
// rtl/d_ram_rd_tag_pipe.sv - owner tag shift register aligned with RAM read latency
module d_ram_rd_tag_pipe
    import d_ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t tags_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags_q[i] <= OWN_NONE;
            end
        end else begin
            tags_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                tags_q[i] <= tags_q[i-1];
            end
        end
    end

    assign tag_o = tags_q[DEPTH-1];

endmodule

// File: rtl/d_ram_port_arbiter.sv
// rtl/d_ram_port_arbiter.sv - CPU-priority data RAM arbiter with DBG anti-starvation and read return routing
module d_ram_port_arbiter
    import d_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    d_ram_port_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              cpu_win, dbg_win;
    owner_t            tag_in, tag_tail;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

    // DBG_FORCE lasts one cycle whatever happens; an absent DBG simply lets the CPU through.
    always_comb begin
        dbg_win    = (state_q == DBG_FORCE) ? bus.dbg_req : (bus.dbg_req && !bus.cpu_req);
        cpu_win    = bus.cpu_req && !dbg_win;
        state_d    = CPU_PRI;
        wait_cnt_d = '0;
        if (state_q == CPU_PRI && bus.dbg_req && !dbg_win) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_d == 4'(MAX_WAIT)) begin
                state_d = DBG_FORCE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CPU_PRI;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        bus.dbg_gnt   = dbg_win;
        bus.cpu_stall = bus.cpu_req && dbg_win;
        bus.ram_en    = cpu_win || dbg_win;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        tag_in        = OWN_NONE;
        if (dbg_win) begin
            bus.ram_we    = bus.dbg_we;
            bus.ram_addr  = bus.dbg_addr;
            bus.ram_wdata = bus.dbg_wdata;
            tag_in        = bus.dbg_we ? OWN_NONE : OWN_DBG;
        end else if (cpu_win) begin
            bus.ram_we    = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
            tag_in        = bus.cpu_we ? OWN_NONE : OWN_CPU;
        end
    end

    d_ram_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_tail)
    );

    // Read data is passed straight through on the valid cycle and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (tag_tail == OWN_CPU) cpu_rdata_q <= bus.ram_rdata;
            if (tag_tail == OWN_DBG) dbg_rdata_q <= bus.ram_rdata;
        end
    end

    always_comb begin
        bus.cpu_rvalid = (tag_tail == OWN_CPU);
        bus.dbg_rvalid = (tag_tail == OWN_DBG);
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : cpu_rdata_q;
        bus.dbg_rdata  = bus.dbg_rvalid ? bus.ram_rdata : dbg_rdata_q;
    end

endmodule

// File: tb/tb_d_ram_port_arbiter.sv
// tb/tb_d_ram_port_arbiter.sv - self-checking bench for the data RAM port arbiter
module tb_d_ram_port_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int RD_LAT   = 1;
    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] cpu_q[$];
    logic [15:0] dbg_q[$];
    logic [15:0] mem [256];

    d_ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    d_ram_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr[7:0]] = bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        end
    end

    // Scoreboard: every rvalid must match the oldest outstanding expectation for that owner.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cpu_rvalid) begin
                checks++;
                if (cpu_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_cpu_unexpected: cpu_rvalid=1 rdata=%h with nothing outstanding", bus.cpu_rdata);
                end else begin
                    logic [15:0] e;
                    e = cpu_q.pop_front();
                    if (bus.cpu_rdata !== e) begin
                        failures++;
                        $display("FAIL sb_cpu_rdata: got %h expected %h", bus.cpu_rdata, e);
                    end
                end
            end
            if (bus.dbg_rvalid) begin
                checks++;
                if (dbg_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_dbg_unexpected: dbg_rvalid=1 rdata=%h with nothing outstanding", bus.dbg_rdata);
                end else begin
                    logic [15:0] e;
                    e = dbg_q.pop_front();
                    if (bus.dbg_rdata !== e) begin
                        failures++;
                        $display("FAIL sb_dbg_rdata: got %h expected %h", bus.dbg_rdata, e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dbg_req   = dr;
        bus.dbg_we    = dw;
        bus.dbg_addr  = da;
        bus.dbg_wdata = dd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.cpu_stall, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.ram_en, bus.ram_we, bus.cpu_stall, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid});
        end
        checks++;
        if ({bus.cpu_rdata, bus.dbg_rdata, bus.ram_addr, bus.ram_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {bus.cpu_rdata, bus.dbg_rdata, bus.ram_addr, bus.ram_wdata});
        end
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 16'h0010) begin
            failures++;
            $display("FAIL reset_pre_read: got en=%b addr=%h expected en=1 addr=0010", bus.ram_en, bus.ram_addr);
        end
        next_cycle();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_inflight: got rvalid=%b rdata=%h expected 0/0000", bus.cpu_rvalid, bus.cpu_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.cpu_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_after_release: cycle %0d got cpu_rvalid=%b dbg_rvalid=%b expected 0", c, bus.cpu_rvalid, bus.dbg_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_cpu_only();
        drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        cpu_q.push_back(16'hBEEF);
        @(negedge clk);
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0020 || bus.cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL cpu_only_issue: got en=%b we=%b addr=%h stall=%b expected 1/0/0020/0", bus.ram_en, bus.ram_we, bus.ram_addr, bus.cpu_stall);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hBEEF || bus.dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL cpu_only_return: got rvalid=%b rdata=%h dbg_rvalid=%b expected 1/beef/0", bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL cpu_only_hold: got rvalid=%b rdata=%h expected 0/beef", bus.cpu_rvalid, bus.cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_idle_cpu();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234);
        @(negedge clk);
        checks++;
        if (bus.dbg_gnt !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 ||
            bus.ram_addr !== 16'h0040 || bus.ram_wdata !== 16'h1234 || bus.cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_cpu_dbg_write: got gnt=%b en=%b we=%b addr=%h wdata=%h stall=%b expected 1/1/1/0040/1234/0",
                     bus.dbg_gnt, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_stall);
        end
        next_cycle();
        drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        cpu_q.push_back(16'h1234);
        @(negedge clk);
        checks++;
        if (bus.dbg_gnt !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_wdata !== 16'h0) begin
            failures++;
            $display("FAIL idle_cpu_readback_issue: got gnt=%b we=%b wdata=%h expected 0/0/0000", bus.dbg_gnt, bus.ram_we, bus.ram_wdata);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_starvation();
        idle();
        next_cycle();
        drive(1'b1, 1'b1, 16'h0060, 16'h5555, 1'b1, 1'b1, 16'h0061, 16'h6666);
        for (int c = 0; c < 10; c++) begin
            logic       exp_dbg;
            logic [15:0] exp_addr;
            exp_dbg  = (c == MAX_WAIT) || (c == 2 * MAX_WAIT + 1);
            exp_addr = exp_dbg ? 16'h0061 : 16'h0060;
            @(negedge clk);
            checks++;
            if (bus.dbg_gnt !== exp_dbg || bus.cpu_stall !== exp_dbg || bus.ram_en !== 1'b1 || bus.ram_addr !== exp_addr) begin
                failures++;
                $display("FAIL starvation_c%0d: got gnt=%b stall=%b en=%b addr=%h expected %b/%b/1/%h",
                         c, bus.dbg_gnt, bus.cpu_stall, bus.ram_en, bus.ram_addr, exp_dbg, exp_dbg, exp_addr);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_force_abort();
        for (int c = 0; c < 10; c++) begin
            logic       dr;
            logic       exp_dbg;
            dr      = (c != MAX_WAIT);
            exp_dbg = (c == 2 * MAX_WAIT + 1);
            drive(1'b1, 1'b1, 16'h0060, 16'h7777, dr, 1'b1, 16'h0061, 16'h8888);
            @(negedge clk);
            checks++;
            if (bus.dbg_gnt !== exp_dbg || bus.cpu_stall !== exp_dbg || bus.ram_en !== 1'b1 ||
                bus.ram_addr !== (exp_dbg ? 16'h0061 : 16'h0060)) begin
                failures++;
                $display("FAIL force_abort_c%0d: got gnt=%b stall=%b en=%b addr=%h expected gnt=%b",
                         c, bus.dbg_gnt, bus.cpu_stall, bus.ram_en, bus.ram_addr, exp_dbg);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_interleaved();
        drive(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        cpu_q.push_back(16'h1111);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
        dbg_q.push_back(16'h2222);
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1111 || bus.dbg_rvalid !== 1'b0 || bus.dbg_gnt !== 1'b1) begin
            failures++;
            $display("FAIL interleaved_c1: got cpu_rvalid=%b cpu_rdata=%h dbg_rvalid=%b gnt=%b expected 1/1111/0/1",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_rvalid, bus.dbg_gnt);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 16'h2222 || bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h1111) begin
            failures++;
            $display("FAIL interleaved_c2: got dbg_rvalid=%b dbg_rdata=%h cpu_rvalid=%b cpu_rdata=%h expected 1/2222/0/1111",
                     bus.dbg_rvalid, bus.dbg_rdata, bus.cpu_rvalid, bus.cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                if (i % 2 == 0) begin
                    drive(1'b1, 1'b0, 16'h0080 + 16'(i), 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
                    cpu_q.push_back(16'hA000 + 16'(i));
                end else begin
                    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0080 + 16'(i), 16'h0);
                    dbg_q.push_back(16'hA000 + 16'(i));
                end
            end else begin
                idle();
            end
            @(negedge clk);
            if (i > 0) begin
                logic exp_cpu;
                exp_cpu = ((i - 1) % 2 == 0);
                checks++;
                if (bus.cpu_rvalid !== exp_cpu || bus.dbg_rvalid !== !exp_cpu) begin
                    failures++;
                    $display("FAIL back_to_back_c%0d: got cpu_rvalid=%b dbg_rvalid=%b expected %b/%b",
                             i, bus.cpu_rvalid, bus.dbg_rvalid, exp_cpu, !exp_cpu);
                end
            end
            next_cycle();
        end
        next_cycle();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        mem[8'h10] = 16'hDEAD;
        mem[8'h20] = 16'hBEEF;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        for (int i = 0; i < 8; i++) mem[8'h80 + i] = 16'hA000 + 16'(i);
        idle();
        #1;
        test_reset();
        test_cpu_only();
        test_idle_cpu();
        test_starvation();
        test_force_abort();
        test_interleaved();
        test_back_to_back();
        checks++;
        if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d cpu and %0d dbg reads outstanding expected 0", cpu_q.size(), dbg_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_ram_port_arbiter.md
Name: d_ram_port_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the pipeline memory-access stage (CPU, primary) and the debug/loader port (DBG, secondary).
- Issues at most one RAM access per cycle and stalls the CPU when it loses arbitration.
- Tracks in-flight reads so read data is returned only to the requester that issued the read.
- Sits between the memory-access address/data generation logic and the data RAM macro.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- RD_LAT, 1, RAM read latency in cycles (1..3).
- MAX_WAIT, 4, consecutive denied DBG cycles before DBG is force-granted (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request this cycle.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_stall  out  1  CPU request not serviced this cycle; CPU must hold its request.
- cpu_rvalid  out  1  CPU load data valid.
- cpu_rdata  out  DATA_W  CPU load data.
- dbg_req  in  1  DBG access request.
- dbg_we  in  1  1=write, 0=read.
- dbg_addr  in  ADDR_W  DBG address.
- dbg_wdata  in  DATA_W  DBG write data.
- dbg_gnt  out  1  DBG request accepted this cycle.
- dbg_rvalid  out  1  DBG read data valid.
- dbg_rdata  out  DATA_W  DBG read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after a read strobe.

Behaviour:
- Clock and reset: single clock domain on clk; rst_n asynchronous, active-low.
- Reset values: wait_cnt=0; owner pipeline cleared; cpu_rvalid=0; dbg_rvalid=0; cpu_rdata=0; dbg_rdata=0.
  - Reset mid-operation discards in-flight reads; no rvalid is produced for them after reset.
- Arbitration state machine (registered, 2 states):
  - CPU_PRI (reset state): CPU wins if cpu_req=1.
    - DBG is granted only when cpu_req=0.
    - Each cycle dbg_req=1 with DBG denied increments wait_cnt.
    - When wait_cnt reaches MAX_WAIT, move to DBG_FORCE.
  - DBG_FORCE: DBG is granted if dbg_req=1; cpu_stall=cpu_req. Return to CPU_PRI next cycle and clear wait_cnt.
    - If dbg_req has dropped, grant the CPU normally, return to CPU_PRI and clear wait_cnt.
  - Any DBG grant clears wait_cnt.
  - A cycle with dbg_req=0 clears wait_cnt; counting is of consecutive denials only.
- Grant outputs (combinational from state and requests, same cycle):
  - dbg_gnt=1 only when DBG wins.
  - cpu_stall=1 iff cpu_req=1 and DBG wins.
  - cpu_stall=0 whenever cpu_req=0.
- RAM drive:
  - ram_en=1 iff a grant occurs.
  - ram_we, ram_addr and ram_wdata come from the winner.
  - With no grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Read return:
  - Each granted read pushes an owner tag (NONE/CPU/DBG) into an RD_LAT-deep shift register. Writes and idle cycles push NONE.
  - At the tail, CPU tag gives cpu_rvalid=1 with cpu_rdata=ram_rdata; DBG tag gives dbg_rvalid=1 with dbg_rdata=ram_rdata.
  - rvalid is a 1-cycle pulse. rdata holds its last value when rvalid=0.
  - Total load latency is RD_LAT cycles after the grant cycle.
- Back-to-back reads from alternating owners return in issue order, one per cycle, with no bubbles.
- Write data is not forwarded: a read of the same address in the cycle after a write returns the RAM contents.
- Addresses and data pass through unmodified: no width conversion and no alignment check.

Decomposition:
- Shared package d_ram_arb_pkg holds:
  - typedef enum owner_t {OWN_NONE, OWN_CPU, OWN_DBG}.
  - typedef enum arb_state_t {CPU_PRI, DBG_FORCE}.
  - Width constants ADDR_W and DATA_W defaults.
- One natural sub-module: d_ram_rd_tag_pipe, the RD_LAT-deep owner tag shift register with async reset.

Test Plan:
- Reset: assert rst_n=0 with a read in flight (cpu_req=1, cpu_we=0, addr 0x0010) -> no cpu_rvalid after release; all outputs 0.
- CPU only: cpu_req load 0x0020, RAM holds 0xBEEF -> ram_en=1 and addr 0x0020 in cycle 0; cpu_rvalid=1 with cpu_rdata=0xBEEF at cycle 1 (RD_LAT=1); cpu_stall=0 throughout.
- Idle CPU: dbg write 0x1234 to 0x0040 with cpu_req=0 -> dbg_gnt=1 the same cycle; ram_we=1, ram_addr=0x0040, ram_wdata=0x1234.
- Starvation: cpu_req and dbg_req held at 1 continuously, MAX_WAIT=4 -> CPU granted cycles 0-3; DBG granted in cycle 4 with cpu_stall=1; CPU granted in cycle 5; next DBG grant in cycle 9.
- Interleaved reads: CPU read 0x0001 (0x1111) in cycle 0, DBG read 0x0002 (0x2222) in cycle 1 -> cpu_rvalid/0x1111 in cycle 1, dbg_rvalid/0x2222 in cycle 2; no cross-delivery.
- Force abort: wait_cnt reaches MAX_WAIT, then dbg_req drops in the DBG_FORCE cycle -> CPU granted, cpu_stall=0, wait_cnt=0.
